// File: rtl/reorder_buffer_pkg.sv
// Shared types and helpers for the reorder buffer: widths, writeback bus
// record, rename entry and the operand-resolution function.
package reorder_buffer_pkg;

    localparam int VREG_W = 5;
    localparam int XLEN   = 32;
    localparam int DEPTH  = 32;

    typedef struct packed {
        logic              en;
        logic [VREG_W-1:0] vregid;
        logic [XLEN-1:0]   val;
    } wb_bus_t;

    typedef struct packed {
        logic              busy;
        logic [VREG_W-1:0] tag;
    } rename_entry_t;

    // Returns {dependent, value}; a pending source carries its tag in the low bits.
    function automatic logic [XLEN:0] rob_lookup(
        input logic [VREG_W-1:0] rs,
        input rename_entry_t     re,
        input logic              ent_ready,
        input logic [XLEN-1:0]   ent_val,
        input logic [XLEN-1:0]   rf_val,
        input wb_bus_t           wb1,
        input wb_bus_t           wb2,
        input wb_bus_t           wb3
    );
        if (rs == '0)                           return '0;
        if (!re.busy)                           return {1'b0, rf_val};
        if (ent_ready)                          return {1'b0, ent_val};
        if (wb1.en && wb1.vregid == re.tag)     return {1'b0, wb1.val};
        if (wb2.en && wb2.vregid == re.tag)     return {1'b0, wb2.val};
        if (wb3.en && wb3.vregid == re.tag)     return {1'b0, wb3.val};
        return {1'b1, {(XLEN-VREG_W){1'b0}}, re.tag};
    endfunction

endpackage

// File: rtl/reorder_buffer_rename_table.sv
// Architectural-register rename map: busy bit plus producing ROB tag per register,
// two lookup ports, one rename write and one commit clear.
module rename_table
    import reorder_buffer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [VREG_W-1:0] rs_a_i,
    input  logic [VREG_W-1:0] rs_b_i,
    output rename_entry_t     ent_a_o,
    output rename_entry_t     ent_b_o,
    input  logic              wr_en_i,
    input  logic [VREG_W-1:0] wr_rd_i,
    input  logic [VREG_W-1:0] wr_tag_i,
    input  logic              clr_en_i,
    input  logic [VREG_W-1:0] clr_rd_i,
    input  logic [VREG_W-1:0] clr_tag_i
);

    rename_entry_t map_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) map_q[i] <= '0;
        end else if (en) begin
            // Only the youngest producer may clear busy; a same-cycle rename of rd wins.
            if (clr_en_i && map_q[clr_rd_i].tag == clr_tag_i &&
                !(wr_en_i && wr_rd_i == clr_rd_i))
                map_q[clr_rd_i].busy <= 1'b0;
            if (wr_en_i && wr_rd_i != '0)
                map_q[wr_rd_i] <= '{busy: 1'b1, tag: wr_tag_i};
        end
    end

    assign ent_a_o = map_q[rs_a_i];
    assign ent_b_o = map_q[rs_b_i];

endmodule

// File: rtl/reorder_buffer.sv
// In-order reorder buffer: allocates vreg tags at issue, resolves operands,
// collects three writeback buses and retires into the architectural register file.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int FULL_SLACK = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hci_rdy,
    input  logic              issue_en,
    input  logic [VREG_W-1:0] issue_rd,
    input  logic [VREG_W-1:0] issue_rs1,
    input  logic [VREG_W-1:0] issue_rs2,
    output logic [VREG_W-1:0] issue_vdest_id,
    output logic              op1_dependent,
    output logic [XLEN-1:0]   op1,
    output logic              op2_dependent,
    output logic [XLEN-1:0]   op2,
    output logic              full,
    input  logic              writeback1_en,
    input  logic [VREG_W-1:0] writeback1_vregid,
    input  logic [XLEN-1:0]   writeback1_val,
    input  logic              writeback2_en,
    input  logic [VREG_W-1:0] writeback2_vregid,
    input  logic [XLEN-1:0]   writeback2_val,
    input  logic              writeback3_en,
    input  logic [VREG_W-1:0] writeback3_vregid,
    input  logic [XLEN-1:0]   writeback3_val,
    output logic              commit_en,
    output logic [VREG_W-1:0] commit_rd,
    output logic [XLEN-1:0]   commit_val
);

    logic [VREG_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [VREG_W:0]   count_q, count_d;
    logic [DEPTH-1:0]  valid_q, ready_q;
    logic [VREG_W-1:0] erd_q  [DEPTH];
    logic [XLEN-1:0]   eval_q [DEPTH];
    logic [XLEN-1:0]   rf_q   [DEPTH];
    logic              commit_en_q;
    logic [VREG_W-1:0] commit_rd_q;
    logic [XLEN-1:0]   commit_val_q;

    wb_bus_t       wbs [3];
    rename_entry_t ren1, ren2;
    logic          do_issue, do_commit;

    assign wbs[0] = '{en: writeback1_en, vregid: writeback1_vregid, val: writeback1_val};
    assign wbs[1] = '{en: writeback2_en, vregid: writeback2_vregid, val: writeback2_val};
    assign wbs[2] = '{en: writeback3_en, vregid: writeback3_vregid, val: writeback3_val};

    assign do_issue  = hci_rdy && issue_en;
    assign do_commit = hci_rdy && count_q != '0 && valid_q[head_q] && ready_q[head_q];

    rename_table u_rename (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (hci_rdy),
        .rs_a_i    (issue_rs1),
        .rs_b_i    (issue_rs2),
        .ent_a_o   (ren1),
        .ent_b_o   (ren2),
        .wr_en_i   (do_issue),
        .wr_rd_i   (issue_rd),
        .wr_tag_i  (tail_q),
        .clr_en_i  (do_commit && erd_q[head_q] != '0),
        .clr_rd_i  (erd_q[head_q]),
        .clr_tag_i (head_q)
    );

    assign {op1_dependent, op1} = rob_lookup(issue_rs1, ren1, ready_q[ren1.tag], eval_q[ren1.tag],
                                             rf_q[issue_rs1], wbs[0], wbs[1], wbs[2]);
    assign {op2_dependent, op2} = rob_lookup(issue_rs2, ren2, ready_q[ren2.tag], eval_q[ren2.tag],
                                             rf_q[issue_rs2], wbs[0], wbs[1], wbs[2]);

    assign issue_vdest_id = tail_q;
    assign full           = int'(count_q) >= DEPTH - FULL_SLACK;
    assign commit_en      = commit_en_q;
    assign commit_rd      = commit_rd_q;
    assign commit_val     = commit_val_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (do_issue)  tail_d = tail_q + 1'b1;
        if (do_commit) head_d = head_q + 1'b1;
        case ({do_issue, do_commit})
            2'b10:   count_d = count_q + 6'd1;
            2'b01:   count_d = count_q - 6'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            ready_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                erd_q[i]  <= '0;
                eval_q[i] <= '0;
            end
        end else if (hci_rdy) begin
            // Lowest-priority bus first so wb1 is the last write and wins.
            for (int k = 2; k >= 0; k--) begin
                if (wbs[k].en && valid_q[wbs[k].vregid] && !ready_q[wbs[k].vregid]) begin
                    ready_q[wbs[k].vregid] <= 1'b1;
                    eval_q[wbs[k].vregid]  <= wbs[k].val;
                end
            end
            if (do_commit) valid_q[head_q] <= 1'b0;
            if (do_issue) begin
                valid_q[tail_q] <= 1'b1;
                ready_q[tail_q] <= 1'b0;
                erd_q[tail_q]   <= issue_rd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            commit_en_q  <= 1'b0;
            commit_rd_q  <= '0;
            commit_val_q <= '0;
            for (int i = 0; i < DEPTH; i++) rf_q[i] <= '0;
        end else if (hci_rdy) begin
            commit_en_q <= do_commit;
            if (do_commit) begin
                commit_rd_q  <= erd_q[head_q];
                commit_val_q <= eval_q[head_q];
                if (erd_q[head_q] != '0) rf_q[erd_q[head_q]] <= eval_q[head_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && do_issue) begin
            assert (count_q != 6'(DEPTH))
            else $fatal(1, "reorder_buffer: issue while all %0d entries are occupied", DEPTH);
        end
    end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Issue-side producer for the reservation stations: allocates the destination vreg tag (`vdest_id`) and resolves `op1`/`op2` dependency for each issued instruction.
- Consumes the three writeback buses to mark entries ready.
- Commits in program order into the internal 32x32 architectural register file.
- Sits between decode and all reservation stations; its issue outputs drive their `in_en`/`vdest_id`/`op*_dependent`/`op*` inputs.

Parameters:
- DEPTH, 32, entry count; fixed by 5-bit vreg id. The tag is the entry index.
- FULL_SLACK, 2, `full` asserts when occupancy >= DEPTH - FULL_SLACK.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset: synchronous, active-low.
- hci_rdy  in  1  global run enable; low freezes all state.
- issue_en  in  1  allocate one entry this cycle.
- issue_rd  in  5  architectural destination register.
- issue_rs1  in  5  architectural source 1.
- issue_rs2  in  5  architectural source 2.
- issue_vdest_id  out  5  tag allocated; combinational, equals tail.
- op1_dependent  out  1  rs1 value is still pending; combinational.
- op1  out  32  value, or {27'b0, tag} when dependent.
- op2_dependent  out  1  same as op1_dependent, for rs2.
- op2  out  32  same as op1, for rs2.
- full  out  1  occupancy >= 30; combinational.
- writeback1_en / writeback1_vregid / writeback1_val  in  1/5/32  result bus 1.
- writeback2_en / writeback2_vregid / writeback2_val  in  1/5/32  result bus 2.
- writeback3_en / writeback3_vregid / writeback3_val  in  1/5/32  result bus 3.
- commit_en  out  1  registered; one entry retired.
- commit_rd  out  5  registered.
- commit_val  out  32  registered.

Behaviour:
- Reset (`rst_n` = 0 at a posedge):
  - head = tail = 0, count = 0; all entry valid/ready = 0.
  - Rename busy[31:0] = 0; regfile all 0.
  - commit_en = 0, commit_rd = 0, commit_val = 0.
  - Reset overrides `hci_rdy`.
- Stall: `hci_rdy` = 0 means no state or output register changes and `issue_en` is ignored. Combinational outputs still reflect current state.
- Entry fields: valid, ready, rd[4:0], val[31:0].
- Operand lookup (per source rs, combinational; uses rename state *before* this cycle's issue update):
  - rs == 0: value 0, not dependent.
  - !busy[rs]: regfile[rs], not dependent.
  - busy[rs] and entry[tag[rs]].ready: entry val, not dependent.
  - busy[rs], entry not ready, and writeback k_en with vregid == tag[rs]: bypass that val, not dependent. Priority wb1 > wb2 > wb3.
  - Otherwise: dependent; op = {27'b0, tag[rs]}.
- Issue (`hci_rdy` && `issue_en`):
  - entry[tail] <= valid = 1, ready = 0, rd = issue_rd.
  - tail <= tail + 1, wrapping mod 32.
  - If issue_rd != 0: busy[rd] <= 1, tag[rd] <= tail.
  - rd == 0 still allocates an entry to preserve order, but renames nothing.
  - Issue while count == 32 is illegal: simulation `$fatal`.
- Writeback: for each enabled bus whose target entry is valid and not ready, set ready = 1 and val = bus val. Writebacks to an invalid entry are ignored. If several buses hit the same entry in one cycle, wb1 > wb2 > wb3.
- Commit (`hci_rdy`, count > 0, entry[head].valid && ready):
  - commit_en <= 1, commit_rd <= rd, commit_val <= val.
  - If rd != 0: regfile[rd] <= val.
  - entry[head].valid <= 0; head <= head + 1 (wraps).
  - busy[rd] <= 0 only if tag[rd] == head and no same-cycle issue renames rd; a same-cycle issue to that rd wins.
  - No commit this cycle: commit_en <= 0; commit_rd/commit_val hold.
  - A writeback arriving at head in cycle N commits at the earliest in cycle N+1. No same-cycle writeback-to-commit bypass.
- Count update: count <= count + issue - commit; simultaneous issue and commit leaves count unchanged.
- Full/empty:
  - count == 0: no commit.
  - Wrap of head/tail through 31 -> 0 is seamless.
- Lookup of a source whose producer commits the same cycle returns the entry value (still valid that cycle), not dependent.

Decomposition:
- Shared package:
  - VREG_W = 5, XLEN = 32, DEPTH = 32.
  - Writeback bus record type {en, vregid, val}.
  - Rename-entry type {busy, tag}.
- Sub-module `rename_table`: 32 busy/tag pairs, two read ports, rename-write port, commit-clear port. Owns the issue-wins-over-clear priority.

Test Plan:
1. Reset, then issue rd=5, rs1=0, rs2=0: vdest_id=0, both ops 0, not dependent. Then wb2 vregid=0 val=0x1234: commit_en=1, commit_rd=5, commit_val=0x1234 the cycle after ready; regfile[5]=0x1234.
2. Issue rd=3 (tag 0), then issue rs1=3: op1_dependent=1, op1=0. Repeat with wb1 for tag 0 in the same cycle as the lookup: op1_dependent=0, op1=wb1_val.
3. Issue 30 entries without writebacks: full=1 at count 30. Write back tags 0..29 in order: 30 consecutive commits; count returns to 0.
4. Issue 40 in steady flow with writebacks so tail wraps 31 -> 0: vdest_id sequence 0..31,0..7; commits in order.
5. Issue rd=7 (tag 4), let it become ready, then issue rd=7 again on the same cycle tag 4 commits: busy[7]=1, tag[7]=5; a later rs1=7 lookup is dependent on 5.
6. Assert hci_rdy=0 for 3 cycles with pending issue_en and writebacks: no state change. Deassert rst_n mid-stream: next cycle count=0, commit_en=0, full=0.
